// File: rtl/div16by8_seq_if.sv
// Handshake/data bundle for div16by8_seq: start + operands in, status + results out.
// exact exists only when DIV_EXACT_CHECK_EN is defined.
interface div16by8_seq_if;
  logic        start;
  logic [15:0] dividend;
  logic [7:0]  divisor;
  logic        busy;
  logic        done;
  logic [15:0] quotient;
  logic [7:0]  remainder;
  logic        dbz;
`ifdef DIV_EXACT_CHECK_EN
  logic        exact;
`endif

  modport master (
    output start,
    output dividend,
    output divisor,
    input  busy,
    input  done,
    input  quotient,
    input  remainder,
`ifdef DIV_EXACT_CHECK_EN
    input  exact,
`endif
    input  dbz
  );

  modport slave (
    input  start,
    input  dividend,
    input  divisor,
    output busy,
    output done,
    output quotient,
    output remainder,
`ifdef DIV_EXACT_CHECK_EN
    output exact,
`endif
    output dbz
  );
endinterface

// File: rtl/div16by8_seq.sv
// Sequential restoring divider, 16b / 8b, one quotient bit per clock (17-cycle latency).
// Ports: clk, rst_n (sync, active-low), bus (slave): start/dividend/divisor in,
// busy/done/quotient/remainder/dbz out. Macro DIV_EXACT_CHECK_EN adds bus.exact.
module div16by8_seq (
  input logic           clk,
  input logic           rst_n,
  div16by8_seq_if.slave bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]  state;
  logic [15:0] dvd_sh;
  logic [7:0]  dvs_q;
  logic [8:0]  prem;
  logic [14:0] q_work;
  logic [4:0]  cnt;

  logic [15:0] quo_q;
  logic [7:0]  rem_q;
  logic        dbz_q;
`ifdef DIV_EXACT_CHECK_EN
  logic        exact_q;
`endif

  logic        accept;
  logic [9:0]  trial;
  logic [8:0]  shifted;
  logic        q_bit;
  logic [8:0]  next_prem;
  logic        last;

  // start is only honoured when not iterating
  assign accept = bus.start &&
                  ((state == S_IDLE) || (state == S_DONE));

  // One restoring step; trial carries an extra sign bit so a
  // negative result is visible in trial[9].
  always_comb begin
    shifted   = {prem[7:0], dvd_sh[15]};
    trial     = {prem, dvd_sh[15]} - {2'b00, dvs_q};
    q_bit     = ~trial[9];
    next_prem = q_bit ? trial[8:0] : shifted;
    last      = (cnt == 5'd15);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      dvd_sh  <= '0;
      dvs_q   <= '0;
      prem    <= '0;
      q_work  <= '0;
      cnt     <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
`ifdef DIV_EXACT_CHECK_EN
      exact_q <= 1'b0;
`endif
    end else begin
      unique case (state)
        S_IDLE, S_DONE: begin
          if (accept) begin
            if (bus.divisor == 8'd0) begin
              state   <= S_DONE;
              quo_q   <= 16'hFFFF;
              rem_q   <= bus.dividend[7:0];
              dbz_q   <= 1'b1;
`ifdef DIV_EXACT_CHECK_EN
              exact_q <= 1'b0;
`endif
            end else begin
              state  <= S_RUN;
              dvd_sh <= bus.dividend;
              dvs_q  <= bus.divisor;
              prem   <= '0;
              q_work <= '0;
              cnt    <= '0;
              dbz_q  <= 1'b0;
            end
          end else begin
            state <= S_IDLE;
          end
        end
        S_RUN: begin
          dvd_sh <= {dvd_sh[14:0], 1'b0};
          prem   <= next_prem;
          q_work <= {q_work[13:0], q_bit};
          cnt    <= cnt + 5'd1;
          if (last) begin
            state   <= S_DONE;
            quo_q   <= {q_work, q_bit};
            rem_q   <= next_prem[7:0];
`ifdef DIV_EXACT_CHECK_EN
            // dividend is a valid 8x8 product of the divisor
            exact_q <= (next_prem[7:0] == 8'd0) &&
                       (q_work[14:7] == 8'd0);
`endif
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy      = (state == S_RUN);
  assign bus.done      = (state == S_DONE);
  assign bus.quotient  = quo_q;
  assign bus.remainder = rem_q;
  assign bus.dbz       = dbz_q;
`ifdef DIV_EXACT_CHECK_EN
  assign bus.exact     = exact_q;
`endif

endmodule

// File: tb/tb_div16by8_seq.sv
// Directed self-checking bench for div16by8_seq.
// Drives on negedge, samples on negedge; define DIV_EXACT_CHECK_EN to also check exact.
module tb_div16by8_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  div16by8_seq_if bus ();

  div16by8_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns cycles from accept edge to done cycle.
  task automatic run_op(input  logic [15:0] a,
                        input  logic [7:0]  b,
                        output int          lat,
                        output logic        saw_busy,
                        output logic        overlap);
    bus.dividend = a;
    bus.divisor  = b;
    bus.start    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    lat = 1;
    saw_busy = bus.busy;
    overlap  = bus.busy & bus.done;
    while (!bus.done && lat < 40) begin
      @(negedge clk);
      lat++;
      if (bus.busy) saw_busy = 1'b1;
      if (bus.busy && bus.done) overlap = 1'b1;
    end
  endtask

  task automatic quiet(input int n, output logic seen);
    seen = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (bus.done) seen = 1'b1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   lat;
    int   lat2;
    logic sb;
    logic ov;
    logic seen;

    bus.start    = 1'b0;
    bus.dividend = 16'h0;
    bus.divisor  = 8'h0;
    rst_n        = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_quo", bus.quotient, 0);
    check("rst_rem", bus.remainder, 0);
    check("rst_dbz", bus.dbz, 0);
`ifdef DIV_EXACT_CHECK_EN
    check("rst_exact", bus.exact, 0);
`endif
    rst_n = 1'b1;
    @(negedge clk);

    // 200*123 inverse
    run_op(16'h6018, 8'd123, lat, sb, ov);
    check("prod_lat", lat, 17);
    check("prod_quo", bus.quotient, 200);
    check("prod_rem", bus.remainder, 0);
    check("prod_dbz", bus.dbz, 0);
    check("prod_busy", sb, 1);
    check("prod_ovl", ov, 0);
`ifdef DIV_EXACT_CHECK_EN
    check("prod_exact", bus.exact, 1);
`endif
    @(negedge clk);
    check("prod_done_pulse", bus.done, 0);
    check("prod_hold", bus.quotient, 200);

    // full range
    run_op(16'hFFFF, 8'hFF, lat, sb, ov);
    check("ffff_quo", bus.quotient, 16'h0101);
    check("ffff_rem", bus.remainder, 0);
`ifdef DIV_EXACT_CHECK_EN
    check("ffff_exact", bus.exact, 0);
`endif
    @(negedge clk);
    run_op(16'd1000, 8'd7, lat, sb, ov);
    check("k7_lat", lat, 17);
    check("k7_quo", bus.quotient, 142);
    check("k7_rem", bus.remainder, 6);
`ifdef DIV_EXACT_CHECK_EN
    check("k7_exact", bus.exact, 0);
`endif
    @(negedge clk);

    // divide by zero
    run_op(16'h1234, 8'd0, lat, sb, ov);
    check("dbz_lat", lat, 1);
    check("dbz_busy", sb, 0);
    check("dbz_quo", bus.quotient, 16'hFFFF);
    check("dbz_rem", bus.remainder, 8'h34);
    check("dbz_flag", bus.dbz, 1);
    @(negedge clk);
    check("dbz_hold", bus.dbz, 1);
    run_op(16'd9, 8'd3, lat, sb, ov);
    check("n9_quo", bus.quotient, 3);
    check("n9_rem", bus.remainder, 0);
    check("n9_dbz", bus.dbz, 0);
`ifdef DIV_EXACT_CHECK_EN
    check("n9_exact", bus.exact, 1);
`endif
    @(negedge clk);

    // start ignored while busy
    bus.dividend = 16'd1000;
    bus.divisor  = 8'd7;
    bus.start    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    lat = 1;
    while (!bus.done && lat < 40) begin
      if (lat == 5) begin
        bus.dividend = 16'h6018;
        bus.divisor  = 8'd123;
        bus.start    = 1'b1;
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    bus.start = 1'b0;
    check("ign_lat", lat, 17);
    check("ign_quo", bus.quotient, 142);
    check("ign_rem", bus.remainder, 6);
    quiet(25, seen);
    check("ign_no_done", seen, 0);

    // back-to-back, start held through DONE
    bus.dividend = 16'd9;
    bus.divisor  = 8'd3;
    bus.start    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    lat = 1;
    while (!bus.done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("b2b_lat1", lat, 17);
    check("b2b_quo1", bus.quotient, 3);
    bus.dividend = 16'd1000;
    bus.divisor  = 8'd7;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    check("b2b_busy", bus.busy, 1);
    lat2 = 1;
    while (!bus.done && lat2 < 40) begin
      @(negedge clk);
      lat2++;
    end
    check("b2b_lat2", lat2, 17);
    check("b2b_quo2", bus.quotient, 142);
    check("b2b_rem2", bus.remainder, 6);
    @(negedge clk);

    // reset mid-run
    bus.dividend = 16'h6018;
    bus.divisor  = 8'd123;
    bus.start    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("mrst_busy", bus.busy, 0);
    check("mrst_done", bus.done, 0);
    check("mrst_quo", bus.quotient, 0);
    check("mrst_rem", bus.remainder, 0);
    rst_n = 1'b1;
    quiet(25, seen);
    check("mrst_no_done", seen, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/div16by8_seq.md
# div16by8_seq

Sequential restoring divider that runs the product path backwards. It accepts a 16-bit dividend, such as a product emitted by the 8×8 multipliers, together with an 8-bit divisor. It returns a 16-bit quotient and an 8-bit remainder, one quotient bit per clock. It sits beside the multiplier array and serves as the golden inverse check: for any multiplier output P = A·B with B ≠ 0, the divider must return quotient = A and remainder = 0.

## Interface
- N, 8, divisor width; dividend and quotient are 2N bits, remainder is N bits. Only N=8 is verified.
- clk  in  1  single clock; all state updates on its rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- start  in  1  request strobe; sampled only in IDLE or DONE.
- dividend  in  16  numerator; captured on the accepting edge.
- divisor  in  8  denominator; captured on the accepting edge.
- busy  out  1  high while an operation is in progress (RUN).
- done  out  1  one-cycle pulse; results are valid in that cycle and held afterwards.
- quotient  out  16  floor(dividend/divisor).
- remainder  out  8  dividend mod divisor.
- dbz  out  1  divide-by-zero flag for the last operation.
- exact  out  1  present only with DIV_EXACT_CHECK_EN; see Configuration.

## Operation
- **States:** IDLE, RUN, DONE. Reset state is IDLE.
- **IDLE:**
  - start=1 with divisor≠0 → capture operands, clear the partial remainder (9 bits) and the 5-bit iteration counter, go to RUN.
  - start=1 with divisor=0 → go to DONE with quotient=16'hFFFF, remainder=dividend[7:0], dbz=1.
  - start=0 → stay in IDLE.
- **RUN:** each cycle performs one restoring step, MSB of the dividend first.
  - Shift the partial remainder left by 1 and insert the next dividend bit.
  - Compute the trial value: partial remainder minus {1'b0, divisor}, 9-bit.
  - If the trial value is non-negative, keep it and shift 1 into the quotient; otherwise keep the shifted value and shift 0.
  - The counter increments; after the 16th step, go to DONE.
- **DONE:** done=1 for exactly this cycle.
  - Next edge: start=1 is accepted exactly as in IDLE (back-to-back operation); otherwise go to IDLE.
- **Held outputs:** quotient, remainder and dbz keep their values until the next accepted start. They are not cleared on the DONE→IDLE transition.
- **dbz:** set only by a divide-by-zero operation; cleared by the next accepted start with divisor≠0.
- **start during RUN:** ignored. Operands and state are unaffected and no request is queued.
- **Operand changes during RUN:** no effect; the captured copies are used.
- **Reset:** rst_n=0 on any edge, including mid-RUN → IDLE. busy, done, dbz, exact = 0; quotient = 0; remainder = 0. The in-flight operation is discarded.

## Timing
- Let start be accepted at edge k.
- Nonzero divisor:
  - Edges k+1…k+16 perform the 16 iterations.
  - busy=1 from after edge k until edge k+16.
  - done=1 and results valid in the cycle after edge k+16.
  - Latency is 17 cycles from the start edge to the done cycle.
- Zero divisor: done=1 in the cycle after edge k. Latency is 1 cycle; busy is never asserted.
- busy and done are never high together.
- Back-to-back: with start=1 in the DONE cycle, the next operation's busy rises after that edge. Throughput is one operation per 17 cycles.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- **DIV_EXACT_CHECK_EN defined:**
  - Port exact exists and is registered, updating when done is asserted.
  - exact=1 iff remainder==0, quotient[15:8]==0 and dbz==0, i.e. the dividend is a valid 8×8 product of the divisor.
  - exact is 0 after reset.
- **DIV_EXACT_CHECK_EN undefined:** port exact and its logic are absent. All other behaviour is identical.

## Test plan
- Inverse of a product: start with dividend=16'h6018 (200·123), divisor=8'd123 → done at start+17, quotient=16'd200, remainder=0, dbz=0, exact=1 if enabled.
- Full range: dividend=16'hFFFF, divisor=8'hFF → quotient=16'h0101, remainder=0. Then dividend=16'd1000, divisor=8'd7 → quotient=16'd142, remainder=8'd6, exact=0.
- Divide by zero: dividend=16'h1234, divisor=0 → done one cycle after the start edge, quotient=16'hFFFF, remainder=8'h34, dbz=1, busy never high. A following 16'd9 / 8'd3 → quotient=3, remainder=0, dbz=0.
- Start ignored while busy: assert start with new operands at start+5 during a 1000/7 operation → the result is still 142 r 6. No second done follows unless start is re-asserted.
- Back-to-back and reset: start held high through DONE → the second operation completes 17 cycles after the first done. Separately, rst_n=0 at start+8 → next cycle shows busy=0, done=0, quotient=0, remainder=0, and no done pulse follows.
